piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out serializer that consumes the 4-bit parallel words produced by the PIPO register stage and emits them one bit per cycle on a serial link. A one-word holding buffer decouples the parallel producer from the shifter, so back-to-back words serialize with no idle bits between them. A valid/ready handshake on both sides lets the downstream consumer stall the stream.

## Interface
- WIDTH, 4: parallel word width in bits. Must be at least 2.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset. Asserting low immediately clears all state; deassertion is synchronous to clk by the integrator.
- data_in  in  WIDTH  parallel word
- in_valid  in  1  data_in is valid
- in_ready  out  1  block can accept a word this cycle
- ser_out  out  1  current serial bit
- ser_valid  out  1  ser_out is valid
- ser_last  out  1  ser_out is the final bit of its word
- out_ready  in  1  consumer accepts ser_out this cycle
- busy  out  1  a word is held or being shifted

## Operation
- Input accept: a word is accepted on an edge where in_valid && in_ready. The accepted word is written to hold_reg and hold_full is set.
- in_ready is a register with reset value 0. It becomes 1 on the first edge after rst deasserts. After that it equals the next-state value of ~hold_full.
- FSM states:
  - IDLE: if hold_full, load hold_reg into the shift register sh_reg, clear hold_full, set cnt=0, go to SHIFT.
  - SHIFT: on each edge with out_ready=1, advance sh_reg by one bit and increment cnt. When cnt=WIDTH-1 and out_ready=1 (the last bit transfers):
    - if hold_full: reload sh_reg from hold_reg, set cnt=0, clear hold_full, stay in SHIFT;
    - otherwise go to IDLE.
- Simultaneous events: a new input accept and a hold-to-shifter transfer on the same edge are legal. The new word lands in hold_reg and hold_full stays 1. in_ready is registered, so it never depends combinationally on out_ready.
- ser_out:
  - MSB_FIRST=1: sh_reg[WIDTH-1]. The register shifts left and fills with 0.
  - MSB_FIRST=0: sh_reg[0]. The register shifts right and fills with 0.
  - ser_out is forced to 0 when ser_valid=0.
- ser_valid = (state==SHIFT). ser_last = ser_valid && (cnt==WIDTH-1).
- busy = (state==SHIFT) || hold_full.
- cnt width is clog2(WIDTH). cnt wraps to 0 only on a reload; it never counts past WIDTH-1.
- Stall: while out_ready=0, sh_reg, cnt, ser_out and ser_last hold their values.
- Input data is not inspected. Every accepted word produces exactly WIDTH serial bits, in order, with no loss or duplication.

## Timing
- Reset values: in_ready=0, ser_out=0, ser_valid=0, ser_last=0, busy=0, state=IDLE, hold_full=0, cnt=0, sh_reg=0, hold_reg=0.
- Latency: a word accepted on edge N sets busy after N. The shifter loads on edge N+1, and the first bit is valid after N+1 (1 cycle from accept to first bit).
- With out_ready held at 1, bit k of a word is valid in the cycle after edge N+1+k. ser_last is high in the cycle after edge N+WIDTH.
- Back-to-back: if the next word is held before the last bit transfers, its first bit follows on the very next cycle, with zero bubble.
- Sustained throughput: one word per WIDTH cycles.
- The producer sees in_ready=0 while the hold buffer is full. A second word can be accepted no earlier than 1 cycle after the first load.
- Reset mid-word: the partial word and any held word are discarded, and outputs go to their reset values asynchronously. The first word accepted after reset serializes from bit 0 of the sequence.

## Test plan
All scenarios use WIDTH=4 unless stated; scenarios 1-5 use MSB_FIRST=1.

1. Reset: hold rst=0 for 2 cycles with in_valid=1 → all outputs 0 throughout. in_ready goes 1 on the first edge after rst=1.
2. Single word: accept 4'b1010 with out_ready=1 → first bit 1 cycle after accept; ser_out sequence 1,0,1,0 on 4 consecutive cycles; ser_last only on the 4th; then ser_valid=0 and busy=0.
3. Back-to-back: offer 4'b1011 then 4'b1001 as soon as in_ready allows → 8 contiguous valid bits 1,0,1,1,1,0,0,1 with ser_last on bits 4 and 8. in_ready drops while the second word is held.
4. Stall: 4'b1010 with out_ready=0 for 3 cycles during bit 2 → ser_out holds 0 and ser_last stays 0 for those cycles; the sequence resumes 1,0 with no bit lost or repeated.
5. Reset mid-operation: accept 4'b1111, then rst=0 during bit 2 → ser_valid=0 immediately. After release, 4'b0110 yields exactly 0,1,1,0.
6. LSB order: MSB_FIRST=0, accept 4'b1010 → ser_out sequence 0,1,0,1 with ser_last on the 4th bit.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer so that
// consecutive words stream out with no idle bits between them.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic             hold_full;
   logic [WIDTH-1:0] hold_reg;
   logic [WIDTH-1:0] sh_reg;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             last_xfer;
   logic             load;
   logic             hold_full_next;
   logic [WIDTH-1:0] sh_shifted;
   logic             sh_bit;

   assign accept    = in_valid && in_ready;
   assign last_xfer = (state == SHIFT) && out_ready && (cnt == LAST_CNT);
   assign load      = hold_full && ((state == IDLE) || last_xfer);

   // A new word may land in the buffer on the same edge the old one leaves it.
   assign hold_full_next = accept || (hold_full && !load);

   assign sh_shifted = MSB_FIRST ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
   assign sh_bit     = MSB_FIRST ? sh_reg[WIDTH-1] : sh_reg[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hold_full <= 1'b0;
         hold_reg  <= '0;
         sh_reg    <= '0;
         cnt       <= '0;
         in_ready  <= 1'b0;
      end else begin
         in_ready  <= ~hold_full_next;
         hold_full <= hold_full_next;
         if (accept) begin
            hold_reg <= data_in;
         end
         case (state)
            IDLE: begin
               if (hold_full) begin
                  sh_reg <= hold_reg;
                  cnt    <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (out_ready) begin
                  if (cnt == LAST_CNT) begin
                     if (hold_full) begin
                        sh_reg <= hold_reg;
                        cnt    <= '0;
                     end else begin
                        sh_reg <= sh_shifted;
                        state  <= IDLE;
                     end
                  end else begin
                     sh_reg <= sh_shifted;
                     cnt    <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ser_valid = (state == SHIFT);
   assign ser_out   = ser_valid && sh_bit;
   assign ser_last  = ser_valid && (cnt == LAST_CNT);
   assign busy      = ser_valid || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus randomized traffic
// checked against a bit-queue model, for both transmit orders.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] data_in   [2];
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic         ser_out   [2];
   logic         ser_valid [2];
   logic         ser_last  [2];
   logic         out_ready [2];
   logic         busy      [2];

   int checks = 0;
   int passes = 0;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .data_in(data_in[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
      .ser_last(ser_last[0]), .out_ready(out_ready[0]), .busy(busy[0])
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .data_in(data_in[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
      .ser_last(ser_last[1]), .out_ready(out_ready[1]), .busy(busy[1])
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit k of a word's transmit sequence, straight from the ordering rule.
   function automatic logic model_bit(input logic [W-1:0] word, input int k, input bit msb);
      int pos;
      pos = msb ? (W - 1 - k) : k;
      return word[pos];
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b1;
         data_in[i]  = 4'hF;
      end
      repeat (2) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({in_ready[i], ser_out[i], ser_valid[i], ser_last[i], busy[i]} !== 5'b0)
               $display("FAIL reset_outputs dut%0d: got %05b expected 00000", i,
                        {in_ready[i], ser_out[i], ser_valid[i], ser_last[i], busy[i]});
            else passes++;
         end
      end
      for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready[0] !== 1'b0) $display("FAIL ready_before_edge: got %0b expected 0", in_ready[0]);
      else passes++;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({in_ready[i], busy[i]} !== 2'b10)
            $display("FAIL ready_after_release dut%0d: got %02b expected 10", i, {in_ready[i], busy[i]});
         else passes++;
      end
   endtask

   task automatic test_single_word(input int i, input logic [W-1:0] w);
      data_in[i]   = w;
      in_valid[i]  = 1'b1;
      out_ready[i] = 1'b1;
      checks++;
      if (in_ready[i] !== 1'b1) $display("FAIL single_ready dut%0d: got %0b expected 1", i, in_ready[i]);
      else passes++;
      tick();
      in_valid[i] = 1'b0;
      checks++;
      if ({busy[i], ser_valid[i]} !== 2'b10)
         $display("FAIL single_latency dut%0d: got busy/valid %02b expected 10", i, {busy[i], ser_valid[i]});
      else passes++;
      for (int k = 0; k < W; k++) begin
         tick();
         checks++;
         if ({ser_valid[i], ser_out[i], ser_last[i]} !== {1'b1, model_bit(w, k, i == 0), (k == W - 1)})
            $display("FAIL single_bit%0d dut%0d: got v/o/l %03b expected %03b", k, i,
                     {ser_valid[i], ser_out[i], ser_last[i]}, {1'b1, model_bit(w, k, i == 0), (k == W - 1)});
         else passes++;
      end
      tick();
      checks++;
      if ({ser_valid[i], busy[i], ser_out[i]} !== 3'b000)
         $display("FAIL single_done dut%0d: got v/busy/o %03b expected 000", i,
                  {ser_valid[i], busy[i], ser_out[i]});
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w0, w1;
      bit   got_bits[$];
      bit   got_last[$];
      int   accepted, gaps;
      bit   seen, ended, acc;
      w0 = 4'b1011; w1 = 4'b1001;
      accepted = 0; gaps = 0; seen = 0; ended = 0;
      data_in[0] = w0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         acc = in_valid[0] && in_ready[0];
         tick();
         if (acc) begin
            accepted++;
            if (accepted == 1) data_in[0] = w1;
            else begin
               in_valid[0] = 1'b0;
               checks++;
               if (in_ready[0] !== 1'b0) $display("FAIL b2b_ready_drop: got %0b expected 0", in_ready[0]);
               else passes++;
            end
         end
         if (ser_valid[0]) begin
            if (ended) gaps++;
            got_bits.push_back(ser_out[0]);
            got_last.push_back(ser_last[0]);
            seen = 1;
         end else if (seen) ended = 1;
      end
      in_valid[0] = 1'b0;
      checks++;
      if (accepted != 2) $display("FAIL b2b_accepts: got %0d expected 2", accepted);
      else passes++;
      checks++;
      if (got_bits.size() != 2 * W || gaps != 0)
         $display("FAIL b2b_contiguous: got %0d bits %0d gaps expected %0d bits 0 gaps",
                  got_bits.size(), gaps, 2 * W);
      else passes++;
      for (int k = 0; k < got_bits.size() && k < 2 * W; k++) begin
         checks++;
         if ({got_bits[k], got_last[k]} !== {model_bit((k < W) ? w0 : w1, k % W, 1), (k % W == W - 1)})
            $display("FAIL b2b_bit%0d: got o/l %02b expected %02b", k, {got_bits[k], got_last[k]},
                     {model_bit((k < W) ? w0 : w1, k % W, 1), (k % W == W - 1)});
         else passes++;
      end
   endtask

   task automatic test_stall();
      data_in[0] = 4'b1010; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      checks++;
      if ({ser_valid[0], ser_out[0]} !== 2'b11) $display("FAIL stall_bit0: got %02b expected 11", {ser_valid[0], ser_out[0]});
      else passes++;
      tick();
      out_ready[0] = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if ({ser_valid[0], ser_out[0], ser_last[0]} !== 3'b100)
            $display("FAIL stall_hold: got v/o/l %03b expected 100", {ser_valid[0], ser_out[0], ser_last[0]});
         else passes++;
      end
      out_ready[0] = 1'b1;
      tick();
      checks++;
      if ({ser_valid[0], ser_out[0], ser_last[0]} !== 3'b110)
         $display("FAIL stall_resume2: got v/o/l %03b expected 110", {ser_valid[0], ser_out[0], ser_last[0]});
      else passes++;
      tick();
      checks++;
      if ({ser_valid[0], ser_out[0], ser_last[0]} !== 3'b101)
         $display("FAIL stall_resume3: got v/o/l %03b expected 101", {ser_valid[0], ser_out[0], ser_last[0]});
      else passes++;
      tick();
      checks++;
      if ({ser_valid[0], busy[0]} !== 2'b00) $display("FAIL stall_done: got %02b expected 00", {ser_valid[0], busy[0]});
      else passes++;
   endtask

   task automatic test_reset_mid();
      data_in[0] = 4'b1111; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      tick();
      data_in[0] = 4'b0101;
      tick();
      in_valid[0] = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({ser_valid[0], ser_out[0], ser_last[0], busy[0], in_ready[0]} !== 5'b0)
         $display("FAIL midreset_async: got %05b expected 00000",
                  {ser_valid[0], ser_out[0], ser_last[0], busy[0], in_ready[0]});
      else passes++;
      tick();
      rst = 1'b1;
      tick();
      test_single_word(0, 4'b0110);
   endtask

   task automatic test_random(input int i);
      bit exp_q[$];
      bit last_q[$];
      for (int c = 0; c < 2000; c++) begin
         data_in[i]   = W'($urandom);
         in_valid[i]  = ($urandom_range(0, 2) != 0);
         out_ready[i] = ($urandom_range(0, 3) != 0);
         checks++;
         if (busy[i] !== (exp_q.size() != 0))
            $display("FAIL rand_busy dut%0d cyc%0d: got %0b expected %0b", i, c, busy[i], exp_q.size() != 0);
         else passes++;
         if (ser_valid[i] && out_ready[i]) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL rand_extra_bit dut%0d cyc%0d: got valid bit expected none", i, c);
            else begin
               if ({ser_out[i], ser_last[i]} !== {exp_q[0], last_q[0]})
                  $display("FAIL rand_bit dut%0d cyc%0d: got o/l %02b expected %02b", i, c,
                           {ser_out[i], ser_last[i]}, {exp_q[0], last_q[0]});
               else passes++;
               void'(exp_q.pop_front());
               void'(last_q.pop_front());
            end
         end
         if (in_valid[i] && in_ready[i]) begin
            for (int k = 0; k < W; k++) begin
               exp_q.push_back(model_bit(data_in[i], k, i == 0));
               last_q.push_back(k == W - 1);
            end
         end
         tick();
      end
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
         if (ser_valid[i]) begin
            checks++;
            if ({ser_out[i], ser_last[i]} !== {exp_q[0], last_q[0]})
               $display("FAIL rand_drain dut%0d: got o/l %02b expected %02b", i,
                        {ser_out[i], ser_last[i]}, {exp_q[0], last_q[0]});
            else passes++;
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || busy[i] !== 1'b0)
         $display("FAIL rand_end dut%0d: got %0d bits left busy %0b expected 0 bits busy 0", i, exp_q.size(), busy[i]);
      else passes++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within budget");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         data_in[i]   = '0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
      end
      #2 rst = 1'b0;
      test_reset();
      test_single_word(0, 4'b1010);
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_single_word(1, 4'b1010);
      test_random(0);
      test_random(1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
